// File: rtl/bldc_pkg.sv
// bldc_pkg: shared FSM encoding and width constants for the encoder sampler
package bldc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_COMMIT, S_CLEAR} state_t;
  localparam int DEF_COUNT_WIDTH = 15;
  localparam int SEL_W = 3;
endpackage

// File: rtl/bldc_encoder_sampler_if.sv
// bldc_encoder_sampler_if: host snapshot register interface
interface bldc_encoder_sampler_if
  import bldc_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) ();
  logic                   clear_req;
  logic                   snap_valid;
  logic                   snap_ack;
  logic [SEL_W-1:0]       rd_sel;
  logic [COUNT_WIDTH-1:0] rd_delta;
  logic                   overrun;
  logic                   busy;
  modport master (output clear_req, snap_ack, rd_sel, input snap_valid, rd_delta, overrun, busy);
  modport slave (input clear_req, snap_ack, rd_sel, output snap_valid, rd_delta, overrun, busy);
endinterface

// File: rtl/bldc_sample_timer.sv
// bldc_sample_timer: free-running period counter, tick on the cycle it wraps
module bldc_sample_timer #(
  parameter int PERIOD = 18000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(PERIOD);
  logic [W-1:0] cnt_q, cnt_d;
  // wrap detection and increment
  always_comb begin
    tick = cnt_q == W'(PERIOD - 1);
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end
  // period counter, never stalled
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bldc_encoder_sampler.sv
// bldc_encoder_sampler: periodic encoder delta capture with host snapshot handshake
module bldc_encoder_sampler
  import bldc_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int PERIOD = 18000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] counts,
  output logic [NUM_CH-1:0]             cnt_reset,
  bldc_encoder_sampler_if.slave         host
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  typedef logic [COUNT_WIDTH-1:0] cnt_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic tick, tick_pend_q, tick_pend_d, clr_pend_q, clr_pend_d;
  logic snap_valid_q, snap_valid_d, overrun_q, overrun_d;
  cnt_t prev_q [NUM_CH];
  cnt_t prev_d [NUM_CH];
  cnt_t work_q [NUM_CH];
  cnt_t work_d [NUM_CH];
  cnt_t snap_q [NUM_CH];
  cnt_t snap_d [NUM_CH];

  bldc_sample_timer #(.PERIOD(PERIOD)) u_timer (.clk(clk), .reset(reset), .tick(tick));

  // state and register banks; reset discards any partial capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      tick_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
      snap_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      prev_q <= '{default: '0};
      work_q <= '{default: '0};
      snap_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      tick_pend_q <= tick_pend_d;
      clr_pend_q <= clr_pend_d;
      snap_valid_q <= snap_valid_d;
      overrun_q <= overrun_d;
      prev_q <= prev_d;
      work_q <= work_d;
      snap_q <= snap_d;
    end

  // sequencer: requests latch as pending, clear is deferred until a capture finishes
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    tick_pend_d = tick_pend_q | tick;
    clr_pend_d = clr_pend_q | host.clear_req;
    snap_valid_d = snap_valid_q & ~host.snap_ack;
    overrun_d = overrun_q & ~host.snap_ack;
    prev_d = prev_q;
    work_d = work_q;
    snap_d = snap_q;
    case (state_q)
      S_IDLE:
        if (clr_pend_q || host.clear_req) state_d = S_CLEAR;
        else if (tick || tick_pend_q) begin
          state_d = S_CAPTURE;
          idx_d = '0;
          tick_pend_d = 1'b0;
        end
      S_CAPTURE: begin
        for (int i = 0; i < NUM_CH; i++)
          if (idx_q == SEL_W'(i)) begin
            work_d[i] = counts[i*COUNT_WIDTH +: COUNT_WIDTH] - prev_q[i];
            prev_d[i] = counts[i*COUNT_WIDTH +: COUNT_WIDTH];
          end
        idx_d = idx_q + SEL_W'(1);
        state_d = idx_q == LAST ? S_COMMIT : S_CAPTURE;
      end
      S_COMMIT: begin
        snap_d = work_q;
        overrun_d = (overrun_q | snap_valid_q) & ~host.snap_ack;
        snap_valid_d = 1'b1;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        prev_d = '{default: '0};
        clr_pend_d = host.clear_req;
        state_d = S_IDLE;
      end
    endcase
  end

  // snapshot read mux; out-of-range selects read zero
  always_comb begin
    host.rd_delta = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (host.rd_sel == SEL_W'(i)) host.rd_delta = snap_q[i];
  end

  assign cnt_reset = {NUM_CH{state_q == S_CLEAR}};
  assign host.snap_valid = snap_valid_q;
  assign host.overrun = overrun_q;
  assign host.busy = state_q != S_IDLE;
endmodule

// File: tb/tb_bldc_encoder_sampler.sv
// tb_bldc_encoder_sampler: directed and randomized checks against a transaction-level model
module tb_bldc_encoder_sampler;
  localparam int N = 2;
  localparam int CW = 15;
  localparam int P = 16;
  localparam int MASK = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N*CW-1:0] counts = '0;
  logic [N-1:0] cnt_reset;
  bldc_encoder_sampler_if #(.COUNT_WIDTH(CW)) h ();
  bldc_encoder_sampler #(.NUM_CH(N), .COUNT_WIDTH(CW), .PERIOD(P)) dut (
    .clk(clk), .reset(reset), .counts(counts), .cnt_reset(cnt_reset), .host(h)
  );
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int prev_m [N];
  int snap_m [N];
  int cur [N];
  bit v_m, o_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  task automatic drive(input int a, input int b);
    cur[0] = a & MASK;
    cur[1] = b & MASK;
    counts = {cur[1][CW-1:0], cur[0][CW-1:0]};
  endtask

  function automatic void model_commit(input bit ack_same);
    for (int i = 0; i < N; i++) begin
      snap_m[i] = (cur[i] - prev_m[i]) & MASK;
      prev_m[i] = cur[i];
    end
    if (ack_same) o_m = 1'b0;
    else if (v_m) o_m = 1'b1;
    v_m = 1'b1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) prev_m[i] = 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, h.snap_valid, v_m);
    chk({tag, "_overrun"}, h.overrun, o_m);
    chk({tag, "_busy"}, h.busy, 0);
    for (int i = 0; i < N; i++) begin
      h.rd_sel = 3'(i);
      #1;
      chk($sformatf("%s_delta%0d", tag, i), h.rd_delta, snap_m[i]);
    end
    h.rd_sel = 3'($urandom_range(N, 7));
    #1;
    chk({tag, "_sel_oob"}, h.rd_delta, 0);
  endtask

  task automatic ack_now();
    h.snap_ack = 1'b1;
    step();
    h.snap_ack = 1'b0;
    if (v_m) begin
      v_m = 1'b0;
      o_m = 1'b0;
    end
    chk("ack_valid", h.snap_valid, v_m);
    chk("ack_overrun", h.overrun, o_m);
  endtask

  task automatic round(input int n, input int a, input int b, input bit ack_same);
    goto(P * n);
    drive(a, b);
    goto(P * n + 1);
    chk("busy_capture", h.busy, 1);
    goto(P * n + 2);
    chk("valid_before_commit", h.snap_valid, v_m);
    if (ack_same) h.snap_ack = 1'b1;
    step();
    h.snap_ack = 1'b0;
    model_commit(ack_same);
    check_all($sformatf("round%0d", n));
  endtask

  initial begin
    int mode;
    h.clear_req = 1'b0;
    h.snap_ack = 1'b0;
    h.rd_sel = '0;
    #1;
    chk("rst_valid", h.snap_valid, 0);
    chk("rst_overrun", h.overrun, 0);
    chk("rst_busy", h.busy, 0);
    chk("rst_cnt_reset", cnt_reset, 0);
    chk("rst_delta", h.rd_delta, 0);
    #1;
    reset = 1'b0;
    drive(100, 0);
    goto(P - 1);
    chk("idle_before_tick", h.busy, 0);
    round(1, 100, 0, 1'b0);
    goto(2 * P - 4);
    ack_now();
    round(2, 130, 32760, 1'b0);
    h.rd_sel = 3'd1;
    #1;
    chk("signed_minus8", 32'($signed(h.rd_delta)), -8);
    goto(3 * P - 4);
    ack_now();
    round(3, 32765, 32760, 1'b0);
    goto(4 * P - 4);
    ack_now();
    round(4, 5, 32760, 1'b0);
    goto(5 * P - 4);
    ack_now();
    round(5, 32765, 32760, 1'b0);
    h.rd_sel = 3'd0;
    #1;
    chk("wrap_back_minus8", 32'($signed(h.rd_delta)), -8);
    round(6, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'b0);
    goto(7 * P - 4);
    ack_now();
    round(7, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'b0);
    round(8, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'b1);
    goto(8 * P + 4);
    ack_now();
    ack_now();
    goto(8 * P + 6);
    h.clear_req = 1'b1;
    step();
    h.clear_req = 1'b0;
    chk("clr_idle_pulse", cnt_reset, 2'b11);
    chk("clr_idle_busy", h.busy, 1);
    model_clear();
    step();
    chk("clr_idle_end", cnt_reset, 0);
    chk("clr_idle_busy_end", h.busy, 0);
    round(9, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'b0);
    goto(10 * P);
    drive(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
    h.clear_req = 1'b1;
    step();
    h.clear_req = 1'b0;
    goto(10 * P + 2);
    chk("clr_cap_deferred", cnt_reset, 0);
    step();
    model_commit(1'b0);
    check_all("clr_cap_commit");
    chk("clr_cap_not_yet", cnt_reset, 0);
    step();
    chk("clr_cap_pulse", cnt_reset, 2'b11);
    model_clear();
    step();
    chk("clr_cap_end", cnt_reset, 0);
    goto(11 * P - 6);
    ack_now();
    goto(11 * P - 2);
    drive(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
    h.clear_req = 1'b1;
    step();
    h.clear_req = 1'b0;
    chk("pend_clear_pulse", cnt_reset, 2'b11);
    model_clear();
    step();
    chk("pend_idle_gap", h.busy, 0);
    step();
    chk("pend_capture", h.busy, 1);
    goto(11 * P + 4);
    model_commit(1'b0);
    check_all("pend_commit");
    ack_now();
    goto(11 * P + 11);
    chk("pend_single_snapshot", h.snap_valid, 0);
    for (int n = 12; n <= 17; n++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 1) begin
        goto(P * n - 4);
        ack_now();
      end
      round(n, prev_m[0] + int'($urandom_range(0, MASK - 1)) - 16383,
            prev_m[1] + int'($urandom_range(0, MASK - 1)) - 16383, mode == 2);
    end
    round(18, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'b0);
    goto(19 * P);
    drive(int'($urandom_range(1, MASK)), int'($urandom_range(1, MASK)));
    goto(19 * P + 1);
    chk("arst_pre_busy", h.busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_busy", h.busy, 0);
    chk("arst_valid", h.snap_valid, 0);
    chk("arst_overrun", h.overrun, 0);
    chk("arst_cnt_reset", cnt_reset, 0);
    chk("arst_delta", h.rd_delta, 0);
    #1;
    reset = 1'b0;
    cyc = 0;
    model_clear();
    v_m = 1'b0;
    o_m = 1'b0;
    round(1, cur[0], cur[1], 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
